clk_divider_multi: RTL and testbench

Parametrised multi-channel integer clock divider generating CHANNELS independent divided clocks from one input clock. It is the successor to the two-output odd/even divider, and it feeds the PWM generators and any logic needing slow enables. Each channel has its own runtime divisor, enable and error flag, plus a one-cycle tick at each output rising edge. Divisor changes take effect only at period boundaries, so outputs never glitch. A common sync input phase-aligns all channels.

---
 rtl/clk_divider_multi.sv | 133 +++++++++++++
 tb/tb_clk_divider_multi.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/clk_divider_multi.sv
// clk_divider_multi: CHANNELS independent runtime-programmable integer clock
// dividers sharing one source clock. Each channel reloads its divisor only at
// a period boundary, so clk_out never glitches. A common sync input restarts
// every enabled, valid channel on the same edge.
// Optional feature macro: CLK_DIV_ODD_DUTY50_EN -- when defined, odd divisors
// get an exact 50% duty cycle via a falling-edge extension flop per channel.
// When it is not defined, all logic runs on the rising edge of clk_in.
module clk_divider_multi #(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned WIDTH    = 12
) (
   input  logic                        clk_in,
   input  logic                        rst,
   input  logic [CHANNELS-1:0]         en,
   input  logic                        sync,
   input  logic [CHANNELS*WIDTH-1:0]   clk_divider,
   output logic [CHANNELS-1:0]         clk_out,
   output logic [CHANNELS-1:0]         tick,
   output logic [CHANNELS-1:0]         div_err
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
      state_t           state_q;
      logic [WIDTH-1:0] div_q;
      logic [WIDTH-1:0] cnt_q;
      logic             clk_q;
      logic             tick_q;
      logic             err_q;

      logic [WIDTH-1:0] div_in;
      logic [WIDTH-1:0] last_cnt;
      logic [WIDTH-1:0] cnt_inc;
      logic [WIDTH-1:0] high_len;
      logic             div_in_ok;
      logic             boundary;

      // Divisor slice for this channel and the counter compare terms.
      assign div_in    = clk_divider[i*WIDTH +: WIDTH];
      assign div_in_ok = (div_in >= WIDTH'(2));
      assign last_cnt  = WIDTH'(div_q - WIDTH'(1));
      assign cnt_inc   = WIDTH'(cnt_q + WIDTH'(1));
      assign high_len  = div_q >> 1;
      assign boundary  = (cnt_q == last_cnt);

      // Channel FSM: idle/reload, start, count, period boundary, disable.
      always_ff @(posedge clk_in or negedge rst) begin
         if (!rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  div_q <= div_in;
                  cnt_q <= '0;
                  if (en[i] && div_in_ok) begin
                     state_q <= RUN;
                     clk_q   <= 1'b1;
                     tick_q  <= 1'b1;
                     err_q   <= 1'b0;
                  end else begin
                     clk_q   <= 1'b0;
                     tick_q  <= 1'b0;
                     err_q   <= en[i] & ~div_in_ok;
                  end
               end
               RUN: begin
                  if (!en[i]) begin
                     // Disable is immediate and wins over sync.
                     state_q <= IDLE;
                     div_q   <= div_in;
                     cnt_q   <= '0;
                     clk_q   <= 1'b0;
                     tick_q  <= 1'b0;
                     err_q   <= 1'b0;
                  end else if (sync || boundary) begin
                     // Restart point: the only place a new divisor is taken.
                     div_q <= div_in;
                     cnt_q <= '0;
                     if (div_in_ok) begin
                        clk_q  <= 1'b1;
                        tick_q <= 1'b1;
                        err_q  <= 1'b0;
                     end else begin
                        state_q <= IDLE;
                        clk_q   <= 1'b0;
                        tick_q  <= 1'b0;
                        err_q   <= 1'b1;
                     end
                  end else begin
                     cnt_q  <= cnt_inc;
                     clk_q  <= (cnt_inc < high_len);
                     tick_q <= 1'b0;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  clk_q   <= 1'b0;
                  tick_q  <= 1'b0;
               end
            endcase
         end
      end

`ifdef CLK_DIV_ODD_DUTY50_EN
      logic neg_q;

      // Half-cycle extension of the high phase for odd divisors.
      always_ff @(negedge clk_in or negedge rst) begin
         if (!rst) begin
            neg_q <= 1'b0;
         end else begin
            neg_q <= clk_q & div_q[0] & (state_q == RUN);
         end
      end

      assign clk_out[i] = clk_q | (neg_q & (state_q == RUN));
`else
      assign clk_out[i] = clk_q;
`endif
      assign tick[i]    = tick_q;
      assign div_err[i] = err_q;
   end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Scoreboard bench for clk_divider_multi (2 channels, 12-bit divisors).
// Stimulus pushes the hand-computed expected outputs after each edge; a
// monitor pops and compares them on the following falling edge.
module tb_clk_divider_multi;

   localparam int unsigned CHANNELS = 2;
   localparam int unsigned WIDTH    = 12;

   logic                      clk_in;
   logic                      rst;
   logic [CHANNELS-1:0]       en;
   logic                      sync;
   logic [CHANNELS*WIDTH-1:0] clk_divider;
   logic [CHANNELS-1:0]       clk_out;
   logic [CHANNELS-1:0]       tick;
   logic [CHANNELS-1:0]       div_err;

   typedef struct {
      logic [1:0] co;
      logic [1:0] tk;
      logic [1:0] er;
      string      nm;
   } exp_t;

   exp_t exp_q[$];
   int   checks;
   int   errors;

   clk_divider_multi #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) dut (
      .clk_in      (clk_in),
      .rst         (rst),
      .en          (en),
      .sync        (sync),
      .clk_divider (clk_divider),
      .clk_out     (clk_out),
      .tick        (tick),
      .div_err     (div_err)
   );

   initial clk_in = 1'b0;
   always #10 clk_in = ~clk_in;

   function automatic logic bit_at(input string s, input int idx);
      if (idx < s.len()) return (s[idx] == 8'h31);
      return 1'b0;
   endfunction

   task automatic check(input string nm, input string what,
                        input logic [1:0] act, input logic [1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s %s: got %b expected %b at %0t", nm, what, act, exp, $time);
      end
   endtask

   // Monitor: one expected vector per falling edge.
   always @(negedge clk_in) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check(e.nm, "clk_out", clk_out, e.co);
         check(e.nm, "tick",    tick,    e.tk);
         check(e.nm, "div_err", div_err, e.er);
      end
   end

   // Drive constant inputs for len(c0) edges; patterns give per-edge outputs.
   task automatic run(input string nm, input logic [1:0] en_v,
                      input logic [11:0] d0, input logic [11:0] d1,
                      input string sy, input string c0, input string t0,
                      input string c1, input string t1,
                      input string e0, input string e1);
      for (int k = 0; k < c0.len(); k++) begin
         exp_t e;
         en          = en_v;
         sync        = bit_at(sy, k);
         clk_divider = {d1, d0};
         @(posedge clk_in);
         #1;
         e.co = {bit_at(c1, k), bit_at(c0, k)};
         e.tk = {bit_at(t1, k), bit_at(t0, k)};
         e.er = {bit_at(e1, k), bit_at(e0, k)};
         e.nm = nm;
         exp_q.push_back(e);
      end
      sync = 1'b0;
   endtask

   // Assert reset shortly after an edge; outputs must clear before the next edge.
   task automatic rst_cyc(input string nm);
      exp_t e;
      @(posedge clk_in);
      #2;
      rst  = 1'b0;
      e.co = 2'b00;
      e.tk = 2'b00;
      e.er = 2'b00;
      e.nm = nm;
      exp_q.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      checks      = 0;
      errors      = 0;
      rst         = 1'b1;
      en          = 2'b00;
      sync        = 1'b0;
      clk_divider = {12'd5, 12'd6};
      #2;
      rst = 1'b0;

      // Reset state
      run("reset", 2'b00, 12'd6, 12'd5, "", "00", "", "", "", "", "");
      rst = 1'b1;

      // ch0 /6 (3H/3L), ch1 /5 (2H/3L)
      run("div6_div5", 2'b11, 12'd6, 12'd5, "",
          "1110001110001", "1000001000001",
          "1100011000110", "1000010000100", "", "");

      // Divisor change 6->4 at cnt=2: current period stays 6
      run("chg_pre", 2'b01, 12'd6, 12'd5, "", "11", "", "", "", "", "");
      run("chg_post", 2'b01, 12'd4, 12'd5, "",
          "00011001100", "00010001000", "", "", "", "");

      // Divisor 1 loaded at boundary -> idle with error, then 4 restarts
      run("div1_err", 2'b01, 12'd1, 12'd5, "", "000", "", "", "", "111", "");
      run("div1_fix", 2'b01, 12'd4, 12'd5, "", "11001", "10001", "", "", "", "");

      // ch0 /4 and ch1 /7 out of phase, then sync aligns both
      run("free_4_7", 2'b11, 12'd4, 12'd7, "",
          "100110", "000100", "111000", "100000", "", "");
      run("sync", 2'b11, 12'd4, 12'd7, "10000",
          "11001", "10001", "11100", "10000", "", "");

      // en[0] dropped while high, then re-enabled
      run("en0_drop", 2'b10, 12'd4, 12'd7, "", "00", "", "00", "", "", "");
      run("en0_reen", 2'b11, 12'd4, 12'd7, "",
          "1100", "1000", "1110", "1000", "", "");

      // Disable and sync on the same edge: disable wins on ch0
      run("dis_vs_sync", 2'b10, 12'd4, 12'd7, "10",
          "00", "", "11", "10", "", "");

      // Invalid divisors: no error while disabled, error once enabled
      run("inv_dis", 2'b00, 12'd1, 12'd0, "", "00", "", "", "", "", "");
      run("inv_en", 2'b01, 12'd1, 12'd0, "", "0", "", "", "", "1", "");

      // Reset mid-period clears outputs asynchronously and holds them low
      run("pre_rst", 2'b11, 12'd6, 12'd5, "", "11", "10", "11", "10", "", "");
      rst_cyc("rst_async");
      run("rst_hold", 2'b11, 12'd6, 12'd5, "", "00", "", "", "", "", "");
      rst = 1'b1;

      // Minimum divisor 2 right after release
      run("div2", 2'b01, 12'd2, 12'd5, "", "1010", "1010", "", "", "", "");

      for (int k = 0; k < 8 && exp_q.size() > 0; k++) @(negedge clk_in);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
